input_conditioner: RTL

//   Upstream front end for the rtl_logic stage. Takes WIDTH raw, asynchronous

---
 rtl/input_conditioner.sv | 78 +++++++
 1 files changed

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - per-channel synchronizer and consecutive-cycle debounce for raw level inputs
// Produces registered clean levels plus one-cycle rise/fall pulses and aggregate changed/stable flags.
module input_conditioner #(
    parameter int WIDTH           = 3,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] x_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed,
    output logic             stable
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Stage 0 samples raw_in; stage SYNC_STAGES-1 is the synchronized level.
    logic [WIDTH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]                  x_q, x_d;
    logic [WIDTH-1:0]                  rise_q, rise_d;
    logic [WIDTH-1:0]                  fall_q, fall_d;
    logic [WIDTH-1:0]                  sync_out;
    logic [WIDTH-1:0]                  chan_idle;

    always_comb begin
        sync_d    = sync_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        rise_d    = '0;
        fall_d    = '0;
        sync_out  = '0;
        chan_idle = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sync_d[i]    = {sync_q[i][SYNC_STAGES-2:0], raw_in[i]};
            sync_out[i]  = sync_q[i][SYNC_STAGES-1];
            chan_idle[i] = (cnt_q[i] == '0) && (sync_out[i] == x_q[i]);
            if (sync_out[i] == x_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                // Level has persisted long enough: accept it and emit the edge pulse.
                x_d[i]    = sync_out[i];
                cnt_d[i]  = '0;
                rise_d[i] = sync_out[i];
                fall_d[i] = ~sync_out[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
            cnt_q  <= '0;
            x_q    <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            x_q    <= x_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign x_out   = x_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
    assign changed = |(rise_q | fall_q);
    assign stable  = &chan_idle;

endmodule
